// File: rtl/alarm_beep_ctrl.sv
// rtl/alarm_beep_ctrl.sv - alarm buzzer sequencer: beeps grouped into bursts, with snooze and stop
//
// Purpose: on an alarm trigger, drive a buzzer with BEEPS beeps per burst
// (T_ON ticks on, T_OFF ticks off), separated by T_GAP ticks of silence,
// for BURSTS bursts, then pulse done. Snooze silences for SNOOZE_T ticks and
// restarts the current burst; stop aborts at once.
//
// Ports:
//   clk       - clock, all state changes on rising edge
//   rst_n     - asynchronous active-low reset
//   tick      - one-cycle time-base enable; durations count ticks
//   trig      - alarm-match pulse, starts a sequence from IDLE
//   stop      - user cancel
//   snooze    - user snooze request
//   buzz      - buzzer drive (registered), high only while beeping
//   active    - high while a sequence is in progress (registered)
//   done      - one-cycle pulse when the last burst completes
//   burst_cnt - completed bursts in the current sequence

module alarm_beep_ctrl #(
  parameter int T_ON     = 3,
  parameter int T_OFF    = 2,
  parameter int T_GAP    = 6,
  parameter int SNOOZE_T = 20,
  parameter int BEEPS    = 4,
  parameter int BURSTS   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       trig,
  input  logic       stop,
  input  logic       snooze,
  output logic       buzz,
  output logic       active,
  output logic       done,
  output logic [3:0] burst_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ON     = 3'd1;
  localparam logic [2:0] S_OFF    = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_SNOOZE = 3'd4;

  // Counter reload values: a state of duration D expires on its D-th tick.
  localparam logic [7:0] LD_ON     = 8'(T_ON - 1);
  localparam logic [7:0] LD_OFF    = 8'(T_OFF - 1);
  localparam logic [7:0] LD_GAP    = 8'(T_GAP - 1);
  localparam logic [7:0] LD_SNOOZE = 8'(SNOOZE_T - 1);
  localparam logic [3:0] LAST_BEEP = 4'(BEEPS - 1);
  localparam logic [3:0] N_BURSTS  = 4'(BURSTS);

  logic [2:0] state, n_state;
  logic [7:0] cnt, n_cnt;
  logic [3:0] beep_idx, n_beep_idx;
  logic [3:0] n_burst_cnt;
  logic       n_done;
  logic [3:0] burst_inc;

  assign burst_inc = burst_cnt + 4'd1;

  always_comb begin
    n_state     = state;
    n_cnt       = cnt;
    n_beep_idx  = beep_idx;
    n_burst_cnt = burst_cnt;
    n_done      = 1'b0;

    if (stop && state != S_IDLE) begin
      n_state = S_IDLE;
      n_cnt   = 8'd0;
    end else if (snooze && (state == S_ON || state == S_OFF || state == S_GAP)) begin
      // Snooze pre-empts a coincident expiry, so no burst is counted here.
      n_state = S_SNOOZE;
      n_cnt   = LD_SNOOZE;
    end else if (state == S_IDLE) begin
      if (trig) begin
        n_state     = S_ON;
        n_cnt       = LD_ON;
        n_beep_idx  = 4'd0;
        n_burst_cnt = 4'd0;
      end
    end else if (tick) begin
      if (cnt != 8'd0) begin
        n_cnt = cnt - 8'd1;
      end else begin
        case (state)
          S_ON: begin
            if (beep_idx != LAST_BEEP) begin
              n_state = S_OFF;
              n_cnt   = LD_OFF;
            end else begin
              n_burst_cnt = burst_inc;
              if (burst_inc == N_BURSTS) begin
                n_state = S_IDLE;
                n_cnt   = 8'd0;
                n_done  = 1'b1;
              end else begin
                n_state = S_GAP;
                n_cnt   = LD_GAP;
              end
            end
          end
          S_OFF: begin
            n_state    = S_ON;
            n_cnt      = LD_ON;
            n_beep_idx = beep_idx + 4'd1;
          end
          S_GAP, S_SNOOZE: begin
            // Both gap and snooze resume at the first beep of a burst.
            n_state    = S_ON;
            n_cnt      = LD_ON;
            n_beep_idx = 4'd0;
          end
          default: begin
            n_state = S_IDLE;
            n_cnt   = 8'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 8'd0;
      beep_idx  <= 4'd0;
      burst_cnt <= 4'd0;
      buzz      <= 1'b0;
      active    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= n_state;
      cnt       <= n_cnt;
      beep_idx  <= n_beep_idx;
      burst_cnt <= n_burst_cnt;
      // Outputs are registered from the next state so they track state exactly.
      buzz      <= (n_state == S_ON);
      active    <= (n_state != S_IDLE);
      done      <= n_done;
    end
  end

endmodule

// File: tb/tb_alarm_beep_ctrl.sv
// tb/tb_alarm_beep_ctrl.sv - self-checking bench for alarm_beep_ctrl

module tb_alarm_beep_ctrl;

  localparam int T_ON     = 3;
  localparam int T_OFF    = 2;
  localparam int T_GAP    = 6;
  localparam int SNOOZE_T = 20;
  localparam int BEEPS    = 4;
  localparam int BURSTS   = 3;
  localparam int PERIOD   = T_ON + T_OFF;
  localparam int BURST_L  = BEEPS * T_ON + (BEEPS - 1) * T_OFF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       trig = 1'b0;
  logic       stop = 1'b0;
  logic       snooze = 1'b0;
  logic       buzz;
  logic       active;
  logic       done;
  logic [3:0] burst_cnt;

  int checks = 0;
  int errors = 0;

  alarm_beep_ctrl #(
    .T_ON(T_ON), .T_OFF(T_OFF), .T_GAP(T_GAP),
    .SNOOZE_T(SNOOZE_T), .BEEPS(BEEPS), .BURSTS(BURSTS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .trig(trig), .stop(stop),
    .snooze(snooze), .buzz(buzz), .active(active), .done(done),
    .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: position in ticks within the current burst+gap cycle.
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_SNZ  = 2;
  int m_mode = M_IDLE;
  int m_p = 0;
  int m_s = 0;
  int m_bursts = 0;
  int m_done = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_p = 0; m_s = 0; m_bursts = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_mode != M_IDLE && stop) begin
        m_mode = M_IDLE;
      end else if (m_mode == M_RUN && snooze) begin
        m_mode = M_SNZ; m_s = 0;
      end else if (m_mode == M_IDLE) begin
        if (trig) begin m_mode = M_RUN; m_p = 0; m_bursts = 0; end
      end else if (tick) begin
        if (m_mode == M_SNZ) begin
          m_s = m_s + 1;
          if (m_s == SNOOZE_T) begin m_mode = M_RUN; m_p = 0; end
        end else begin
          m_p = m_p + 1;
          if (m_p == BURST_L) begin
            m_bursts = m_bursts + 1;
            if (m_bursts == BURSTS) begin m_mode = M_IDLE; m_done = 1; end
          end else if (m_p == BURST_L + T_GAP) begin
            m_p = 0;
          end
        end
      end
    end
  end

  function automatic int exp_buzz();
    return (m_mode == M_RUN && m_p < BURST_L && (m_p % PERIOD) < T_ON) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("buzz", int'(buzz), exp_buzz());
    chk("active", int'(active), (m_mode != M_IDLE) ? 1 : 0);
    chk("done", int'(done), m_done);
    chk("burst_cnt", int'(burst_cnt), m_bursts);
  end

  logic       smp_buzz, smp_act, smp_done;
  logic [3:0] smp_bc;

  task automatic cycle(input logic t, input logic tr, input logic st, input logic sn);
    @(negedge clk);
    smp_buzz = buzz; smp_act = active; smp_done = done; smp_bc = burst_cnt;
    tick = t; trig = tr; stop = st; snooze = sn;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int hi, act_n, dn, z, pat;
    logic s [0:40];

    #3;
    chk("reset_buzz", int'(buzz), 0);
    chk("reset_active", int'(active), 0);
    chk("reset_burst_cnt", int'(burst_cnt), 0);
    cycle(1, 0, 0, 0);
    rst_n = 1'b1;
    repeat (3) cycle(1, 0, 0, 0);

    // Full sequence, with a trig pulse during the first OFF.
    hi = 0; act_n = 0; dn = 0; pat = 0;
    cycle(1, 1, 0, 0);
    for (int i = 1; i <= 70; i++) begin
      cycle(1, (i == 4), 0, 0);
      hi += int'(smp_buzz); act_n += int'(smp_act); dn += int'(smp_done);
      if (i <= 5) pat = (pat << 1) | int'(smp_buzz);
      if (i == 18) chk("bc_before_burst_end", int'(smp_bc), 0);
      if (i == 19) chk("bc_after_burst_end", int'(smp_bc), 1);
    end
    chk("first_pattern", pat, 5'b11100);
    chk("buzz_high_total", hi, 36);
    chk("active_total", act_n, 66);
    chk("done_pulses", dn, 1);
    chk("final_burst_cnt", int'(smp_bc), 3);

    // Slow tick: one tick every 4th cycle.
    for (int i = 0; i <= 40; i++) begin
      cycle((i % 4) == 0, (i == 0), 0, 0);
      s[i] = smp_buzz;
    end
    z = 1;
    while (z <= 40 && s[z]) z++;
    chk("slow_on_span", z - 1, 12);
    hi = z;
    while (z <= 40 && !s[z]) z++;
    chk("slow_off_span", z - hi, 8);
    cycle(1, 0, 1, 0);
    repeat (2) cycle(1, 0, 0, 0);

    // Snooze during 2nd beep of burst 2.
    cycle(1, 1, 0, 0);
    for (int i = 2; i <= 30; i++) cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 1);
    z = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1, 0, 0, 0);
      if (smp_buzz) break;
      z++;
    end
    chk("snooze_silence", z, 20);
    chk("snooze_resume_bc", int'(smp_bc), 1);
    repeat (12) cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 0);
    repeat (2) cycle(1, 0, 0, 0);

    // Stop and snooze together during ON.
    cycle(1, 1, 0, 0);
    for (int i = 2; i <= 25; i++) cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 1);
    cycle(1, 0, 0, 0);
    chk("stop_active", int'(smp_act), 0);
    chk("stop_buzz", int'(smp_buzz), 0);
    chk("stop_bc_hold", int'(smp_bc), 1);
    dn = int'(smp_done);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0, 0);
      dn += int'(smp_done);
    end
    chk("stop_no_done", dn, 0);

    // Reset during GAP.
    cycle(1, 1, 0, 0);
    for (int i = 2; i <= 21; i++) cycle(1, 0, 0, 0);
    chk("pre_reset_active", int'(smp_act), 1);
    chk("pre_reset_bc", int'(smp_bc), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_buzz", int'(buzz), 0);
    chk("rst_active", int'(active), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_bc", int'(burst_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 1, 0, 0);
    cycle(1, 0, 0, 0);
    chk("restart_buzz", int'(smp_buzz), 1);
    chk("restart_bc", int'(smp_bc), 0);

    // Randomized traffic checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 149) == 0, $urandom_range(0, 59) == 0);
      rst_n = ($urandom_range(0, 999) != 0);
    end
    rst_n = 1'b1;
    repeat (3) cycle(1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
